// File: rtl/ev22_inst_fetch_pkg.sv
// Shared EV22 definitions used by the fetch front end.
//   - instruction width and the NOP encoding (decodes as NOP in both nybble decoders)
//   - opcode nybble field bounds for the first/second microinstruction decoders
//   - fetch FSM state encoding
package ev22_inst_fetch_pkg;

  localparam int unsigned Ev22InstW = 20;
  localparam logic [Ev22InstW-1:0] Ev22Nop = 20'h00000;

  // Opcode nybble fields
  localparam int unsigned Op1Hi = 19;
  localparam int unsigned Op1Lo = 16;
  localparam int unsigned Op2Hi = 15;
  localparam int unsigned Op2Lo = 12;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,  // no request outstanding
    StReq     = 2'b01,  // request outstanding, data will be queued
    StDiscard = 2'b10   // request outstanding, data will be dropped (redirected)
  } fetch_state_e;

  function automatic logic [3:0] op1_nybble(input logic [Ev22InstW-1:0] inst);
    return inst[Op1Hi:Op1Lo];
  endfunction

  function automatic logic [3:0] op2_nybble(input logic [Ev22InstW-1:0] inst);
    return inst[Op2Hi:Op2Lo];
  endfunction

endpackage

// File: rtl/ev22_ifetch_buf.sv
// Prefetch queue: Depth x Width synchronous FIFO.
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (empties the queue)
//   flush_i      empty the queue; wins over push_i/pop_i
//   push_i       write push_data_i at the tail (ignored when full)
//   push_data_i  entry to write
//   pop_i        drop the head entry (ignored when empty)
//   head_o       head entry, read from registered storage
//   count_o      number of valid entries
// Depth must be a power of two so the pointers wrap naturally.
module ev22_ifetch_buf #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  always_comb begin
    push_en  = push_i && !flush_i && (count_q != CntW'(Depth));
    pop_en   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_en && !pop_en) begin
        count_d = count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed when count_q != 0.
  always_ff @(posedge clk_i) begin
    if (push_en && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ev22_inst_fetch.sv
// EV22 instruction fetch front end.
// Fetches instruction words over a REQ/ACK memory port into a small prefetch
// queue and presents one word per cycle to the decode stage. A branch redirect
// squashes the queue head, flushes the queue and drops any in-flight fetch.
//   CLK, RST              clock; synchronous active-high reset
//   IMEM_REQ/IMEM_ADDR    read request and address, held until IMEM_ACK
//   IMEM_ACK/IMEM_DATA    read completion and data
//   INST/INST_PC          queue head to decode (NOP and 0 when not valid)
//   INST_VALID/DEC_READY  decode handshake
//   BR_TAKEN/BR_TARGET    redirect pulse and address
//   FETCH_CNT/FLUSH_CNT   saturating stats, present only when IFETCH_STATS_EN
//                         is defined, otherwise tied to 0
module ev22_inst_fetch
  import ev22_inst_fetch_pkg::*;
#(
  parameter int unsigned    ADDR_W    = 12,
  parameter int unsigned    INST_W    = Ev22InstW,
  parameter int unsigned    BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [INST_W-1:0] IMEM_DATA,
  output logic [INST_W-1:0] INST,
  output logic [ADDR_W-1:0] INST_PC,
  output logic              INST_VALID,
  input  logic              DEC_READY,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  output logic [15:0]       FETCH_CNT,
  output logic [15:0]       FLUSH_CNT
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);
  localparam logic [CntW-1:0] DepthM1  = CntW'(BUF_DEPTH - 1);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;              // next address to fetch
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d; // address of the request being discarded

  logic                     buf_push, buf_pop;
  logic [CntW-1:0]          buf_count;
  logic [INST_W+ADDR_W-1:0] buf_head;
  logic [CntW-1:0]          count_after;  // occupancy after this cycle's pop/flush
  logic                     inst_valid;

  assign inst_valid = (buf_count != '0) && !BR_TAKEN;
  assign buf_pop    = inst_valid && DEC_READY;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    buf_push    = 1'b0;
    IMEM_REQ    = 1'b0;
    IMEM_ADDR   = '0;
    count_after = BR_TAKEN ? '0 : (buf_count - CntW'(buf_pop));

    unique case (state_q)
      StIdle: begin
        if (BR_TAKEN) pc_d = BR_TARGET;
        if (count_after < DepthCnt) state_d = StReq;
      end
      StReq: begin
        IMEM_REQ  = 1'b1;
        IMEM_ADDR = pc_q;
        if (BR_TAKEN) begin
          pc_d        = BR_TARGET;
          disc_addr_d = pc_q;
          // A coincident ACK completes the old fetch, so nothing is left to drop.
          state_d     = IMEM_ACK ? StReq : StDiscard;
        end else if (IMEM_ACK) begin
          buf_push = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
          // Keep requesting only if a slot is still free after this push.
          state_d  = (count_after < DepthM1) ? StReq : StIdle;
        end
      end
      StDiscard: begin
        IMEM_REQ  = 1'b1;
        IMEM_ADDR = disc_addr_q;
        if (BR_TAKEN) pc_d = BR_TARGET;
        if (IMEM_ACK) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
    end
  end

  ev22_ifetch_buf #(
    .Depth (BUF_DEPTH),
    .Width (INST_W + ADDR_W),
    .CntW  (CntW)
  ) u_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (BR_TAKEN),
    .push_i      (buf_push),
    .push_data_i ({IMEM_DATA, pc_q}),
    .pop_i       (buf_pop),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign INST_VALID = inst_valid;
  assign INST       = inst_valid ? buf_head[INST_W+ADDR_W-1:ADDR_W] : INST_W'(Ev22Nop);
  assign INST_PC    = inst_valid ? buf_head[ADDR_W-1:0] : '0;

`ifdef IFETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (buf_push && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (BR_TAKEN && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign FETCH_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: doc/ev22_inst_fetch.md
Name: ev22_inst_fetch

Overview:
- Front end of the EV22 pipeline.
- Fetches 20-bit instruction words from program memory over a REQ/ACK read interface.
- Buffers them in a small prefetch queue and presents one word per cycle to the decode stage (first- and second-nybble microinstruction decoders).
- Supports decode back-pressure and a branch redirect that flushes queued and in-flight fetches.

Parameters:
ADDR_W, 12, program-memory word address width
INST_W, 20, instruction width (fixed 20 for EV22)
BUF_DEPTH, 2, prefetch queue entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  synchronous, active-high reset
IMEM_REQ  out  1  read request, held until ACK
IMEM_ADDR  out  ADDR_W  read address, stable while IMEM_REQ=1
IMEM_ACK  in  1  read complete; IMEM_DATA valid this cycle
IMEM_DATA  in  INST_W  fetched word
INST  out  INST_W  instruction to decoders; NOP word (all zero) when not valid
INST_PC  out  ADDR_W  address of INST
INST_VALID  out  1  INST holds a real instruction
DEC_READY  in  1  decode accepts INST this cycle
BR_TAKEN  in  1  redirect pulse from execute
BR_TARGET  in  ADDR_W  redirect address
FETCH_CNT  out  16  stats (see Optional Feature)
FLUSH_CNT  out  16  stats (see Optional Feature)

Behaviour:
- Reset (synchronous, RST=1 at a clock edge):
  - fetch PC=RESET_PC, queue empty, state IDLE.
  - IMEM_REQ=0, INST=0, INST_PC=0, INST_VALID=0, counters=0.
  - Applies mid-transaction: the outstanding request is abandoned; a memory ACK in the reset cycle is ignored.
- FSM states:
  - IDLE: no request outstanding. Go to REQ when (queue count + 0 in-flight) < BUF_DEPTH. This enters REQ the cycle after reset deasserts.
  - REQ: IMEM_REQ=1, IMEM_ADDR=fetch PC.
    - On ACK: push IMEM_DATA with its PC and increment PC modulo 2^ADDR_W (wrap to 0).
    - Then stay in REQ if space remains after the push and pop of this cycle, otherwise go to IDLE.
  - DISCARD: entered when BR_TAKEN occurs while in REQ without ACK in the same cycle. IMEM_REQ stays 1 with the old address until ACK, then the data is dropped. Next state REQ at BR_TARGET.
- Memory protocol:
  - Minimum latency 1 cycle: REQ rises at edge N, ACK is sampled at edge N+1 at the earliest.
  - Back-to-back: REQ stays high, address advances the cycle after ACK.
- Output / handshake:
  - INST/INST_PC = queue head, combinational from registered storage.
  - INST_VALID = (count!=0) && !BR_TAKEN.
  - Transfer when INST_VALID && DEC_READY: pop head.
  - When not valid, INST = 20'h00000, which decodes as NOP in both decoders.
- Redirect (BR_TAKEN=1):
  - Queue cleared; the head in that cycle is squashed, not popped.
  - Fetch PC <= BR_TARGET.
  - ACK in the same cycle: data dropped; next state REQ at BR_TARGET.
  - BR_TAKEN has priority over push, pop and ACK.
- Simultaneous push and pop with a full queue:
  - Never occurs, because requests issue only with a free slot counted including in-flight.
  - Push and pop in the same cycle leave count unchanged.
- Throughput: with 1-cycle memory and DEC_READY=1, steady state is 1 instruction per cycle. The first INST_VALID occurs 2 cycles after reset deasserts with immediate ACK.

Optional Feature:
- Macro IFETCH_STATS_EN.
- Defined:
  - FETCH_CNT: 16-bit saturating count of accepted ACKs that were pushed.
  - FLUSH_CNT: 16-bit saturating count of BR_TAKEN cycles.
  - Both cleared by RST.
- Undefined: both ports tied to 0 and no counter flops are generated. All other behaviour is identical.

Decomposition:
- Shared header with the existing instruction lists:
  - INST_W=20.
  - NOP encoding 20'h00000.
  - Opcode field bounds (first nybble [19:16], second nybble [15:12]).
  - Fetch FSM state encodings IDLE/REQ/DISCARD.
- One sub-module, ev22_ifetch_buf:
  - BUF_DEPTH x (INST_W+ADDR_W) synchronous FIFO with push, pop, flush, count, head outputs and synchronous reset.
  - Flush has priority over push/pop.

Test Plan:
- Reset then 1-cycle-ACK memory returning word = 20'h10000 + addr, DEC_READY=1 → INST_VALID first high 2 cycles after reset release; INST_PC 0,1,2,3 on consecutive cycles; INST=20'h10000..20'h10003.
- DEC_READY=0 for 6 cycles → exactly BUF_DEPTH=2 words queued, IMEM_REQ drops to 0, INST holds PC 0. On release, PCs 0,1,2 are delivered in order with no loss or duplication.
- BR_TAKEN with BR_TARGET=12'h080 while a request to 12'h005 awaits ACK (ACK delayed 3 cycles) → REQ holds addr 005 until ACK, that data is dropped, the next request is to 080, and the first valid INST_PC=080.
- BR_TAKEN coinciding with ACK and DEC_READY=1 → INST_VALID=0 that cycle, queue empty next cycle, ACK data discarded, next IMEM_ADDR=BR_TARGET.
- Fetch from PC 12'hFFE with ADDR_W=12 → addresses FFE, FFF, 000, 001.
- RST asserted mid-REQ with ACK arriving the same cycle → all outputs 0 next cycle and the ACK data is never presented. With IFETCH_STATS_EN, FETCH_CNT=0 and FLUSH_CNT=0.
